ps2_scancode_decoder: RTL and testbench

Receives the raw PS/2 keyboard serial stream (scancode set 2), deframes and checks each byte, and resolves the E0/F0/E1 prefix sequences. It emits one strobed internal keycode per make or break event. It sits directly upstream of the ASCII keycode converter and drives that block's `key_data_stb`, `key_broken` and `key_data` inputs unchanged.

---
 rtl/ps2_scancode_decoder.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ps2_scancode_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_decoder.sv
// PS/2 keyboard receiver and scancode set 2 decoder.
// Takes the raw PS/2 clock and data pins and checks each 11-bit frame.
// It resolves the E0/F0/E1 prefix sequences and emits one strobed internal
// keycode per mapped make or break event.
module ps2_scancode_decoder #(
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       key_data_stb,
    output logic       key_broken,
    output logic [7:0] key_data,
    output logic       frame_err
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_PAUSE   = 3'd4
    } state_t;

    // Odd parity holds when data plus parity bit carry an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
        return ^{d, p};
    endfunction

    // Scancode to internal keycode; bit 8 flags a mapped code.
    function automatic logic [8:0] keymap(input logic ext, input logic [7:0] code);
        logic [8:0] r;
        r = 9'd0;
        if (ext) begin
            case (code)
                8'h14:   r = {1'b1, 8'h2E};
                8'h11:   r = {1'b1, 8'h2F};
                default: r = 9'd0;
            endcase
        end else begin
            case (code)
                8'h1C: r = {1'b1, 8'h01};  8'h32: r = {1'b1, 8'h02};
                8'h21: r = {1'b1, 8'h03};  8'h23: r = {1'b1, 8'h04};
                8'h24: r = {1'b1, 8'h05};  8'h2B: r = {1'b1, 8'h06};
                8'h34: r = {1'b1, 8'h07};  8'h33: r = {1'b1, 8'h08};
                8'h43: r = {1'b1, 8'h09};  8'h3B: r = {1'b1, 8'h0A};
                8'h42: r = {1'b1, 8'h0B};  8'h4B: r = {1'b1, 8'h0C};
                8'h3A: r = {1'b1, 8'h0D};  8'h31: r = {1'b1, 8'h0E};
                8'h44: r = {1'b1, 8'h0F};  8'h4D: r = {1'b1, 8'h10};
                8'h15: r = {1'b1, 8'h11};  8'h2D: r = {1'b1, 8'h12};
                8'h1B: r = {1'b1, 8'h13};  8'h2C: r = {1'b1, 8'h14};
                8'h3C: r = {1'b1, 8'h15};  8'h2A: r = {1'b1, 8'h16};
                8'h1D: r = {1'b1, 8'h17};  8'h22: r = {1'b1, 8'h18};
                8'h35: r = {1'b1, 8'h19};  8'h1A: r = {1'b1, 8'h1A};
                8'h45: r = {1'b1, 8'h1B};  8'h16: r = {1'b1, 8'h1C};
                8'h1E: r = {1'b1, 8'h1D};  8'h26: r = {1'b1, 8'h1E};
                8'h25: r = {1'b1, 8'h1F};  8'h2E: r = {1'b1, 8'h20};
                8'h36: r = {1'b1, 8'h21};  8'h3D: r = {1'b1, 8'h22};
                8'h3E: r = {1'b1, 8'h23};  8'h46: r = {1'b1, 8'h24};
                8'h29: r = {1'b1, 8'h25};  8'h5A: r = {1'b1, 8'h26};
                8'h66: r = {1'b1, 8'h27};  8'h58: r = {1'b1, 8'h2C};
                8'h12: r = {1'b1, 8'h2D};  8'h59: r = {1'b1, 8'h2D};
                8'h14: r = {1'b1, 8'h2E};  8'h11: r = {1'b1, 8'h2F};
                default: r = 9'd0;
            endcase
        end
        return r;
    endfunction

    logic          ps2_clk_meta_r, ps2_clk_sync_r, ps2_clk_prev_r;
    logic          ps2_data_meta_r, ps2_data_sync_r;
    logic          fall_s, timeout_s;
    logic [3:0]    bit_cnt_r;
    logic [7:0]    shift_r;
    logic          parity_r;
    logic [CW-1:0] cyc_cnt_r;
    logic          byte_vld_r, rx_abort_r, frame_err_r;
    logic [7:0]    byte_r;
    state_t        state_r, state_nxt_s;
    logic [2:0]    skip_r, skip_nxt_s;
    logic          look_s, look_ext_s, look_brk_s, emit_s;
    logic [8:0]    map_s;
    logic          key_data_stb_r, key_broken_r;
    logic [7:0]    key_data_r;

    // Two-flop synchronizers plus previous-sample register for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps2_clk_meta_r  <= 1'b1;
            ps2_clk_sync_r  <= 1'b1;
            ps2_clk_prev_r  <= 1'b1;
            ps2_data_meta_r <= 1'b1;
            ps2_data_sync_r <= 1'b1;
        end else begin
            ps2_clk_meta_r  <= ps2_clk;
            ps2_clk_sync_r  <= ps2_clk_meta_r;
            ps2_clk_prev_r  <= ps2_clk_sync_r;
            ps2_data_meta_r <= ps2_data;
            ps2_data_sync_r <= ps2_data_meta_r;
        end
    end

    assign fall_s    = ps2_clk_prev_r & ~ps2_clk_sync_r;
    assign timeout_s = (bit_cnt_r != 4'd0) && (cyc_cnt_r == CW'(TIMEOUT_CYCLES));

    // Idle-cycle counter between PS/2 clock edges; only runs inside a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_cnt_r <= '0;
        end else if (fall_s || (bit_cnt_r == 4'd0) || timeout_s) begin
            cyc_cnt_r <= '0;
        end else begin
            cyc_cnt_r <= cyc_cnt_r + CW'(1);
        end
    end

    // Frame deserializer: start check, data shift, parity/stop check, timeout abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_r   <= 4'd0;
            shift_r     <= 8'd0;
            parity_r    <= 1'b0;
            byte_r      <= 8'd0;
            byte_vld_r  <= 1'b0;
            rx_abort_r  <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            byte_vld_r  <= 1'b0;
            rx_abort_r  <= 1'b0;
            frame_err_r <= 1'b0;
            if (fall_s) begin
                case (bit_cnt_r)
                    4'd0: begin
                        if (ps2_data_sync_r) begin
                            frame_err_r <= 1'b1;
                        end else begin
                            bit_cnt_r <= 4'd1;
                        end
                    end
                    4'd9: begin
                        parity_r  <= ps2_data_sync_r;
                        bit_cnt_r <= 4'd10;
                    end
                    4'd10: begin
                        bit_cnt_r <= 4'd0;
                        if (ps2_data_sync_r && odd_parity_ok(shift_r, parity_r)) begin
                            byte_r     <= shift_r;
                            byte_vld_r <= 1'b1;
                        end else begin
                            frame_err_r <= 1'b1;
                            rx_abort_r  <= 1'b1;
                        end
                    end
                    default: begin
                        if (bit_cnt_r <= 4'd8) begin
                            shift_r   <= {ps2_data_sync_r, shift_r[7:1]};
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                        end else begin
                            bit_cnt_r <= 4'd0;
                        end
                    end
                endcase
            end else if (timeout_s) begin
                bit_cnt_r   <= 4'd0;
                frame_err_r <= 1'b1;
                rx_abort_r  <= 1'b1;
            end
        end
    end

    // Prefix FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            skip_r  <= 3'd0;
        end else begin
            state_r <= state_nxt_s;
            skip_r  <= skip_nxt_s;
        end
    end

    // Prefix FSM next state and keycode lookup request.
    always_comb begin
        state_nxt_s = state_r;
        skip_nxt_s  = skip_r;
        look_s      = 1'b0;
        look_ext_s  = 1'b0;
        look_brk_s  = 1'b0;
        if (rx_abort_r) begin
            state_nxt_s = ST_IDLE;
            skip_nxt_s  = 3'd0;
        end else if (byte_vld_r) begin
            case (state_r)
                ST_IDLE: begin
                    case (byte_r)
                        8'hE0: state_nxt_s = ST_EXT;
                        8'hF0: state_nxt_s = ST_BRK;
                        8'hE1: begin
                            state_nxt_s = ST_PAUSE;
                            skip_nxt_s  = 3'd7;
                        end
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: state_nxt_s = ST_IDLE;
                        default: look_s = 1'b1;
                    endcase
                end
                ST_EXT: begin
                    if (byte_r == 8'hF0) begin
                        state_nxt_s = ST_EXT_BRK;
                    end else begin
                        look_s      = 1'b1;
                        look_ext_s  = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    look_s      = 1'b1;
                    look_brk_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_EXT_BRK: begin
                    look_s      = 1'b1;
                    look_ext_s  = 1'b1;
                    look_brk_s  = 1'b1;
                    state_nxt_s = ST_IDLE;
                end
                ST_PAUSE: begin
                    if (skip_r <= 3'd1) begin
                        skip_nxt_s  = 3'd0;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        skip_nxt_s  = skip_r - 3'd1;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    skip_nxt_s  = 3'd0;
                end
            endcase
        end else begin
            state_nxt_s = state_r;
        end
        map_s  = keymap(look_ext_s, byte_r);
        emit_s = look_s & map_s[8];
    end

    // Output register: strobe for one cycle, data and break flag held between strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_data_stb_r <= 1'b0;
            key_broken_r   <= 1'b0;
            key_data_r     <= 8'd0;
        end else begin
            key_data_stb_r <= emit_s;
            if (emit_s) begin
                key_data_r   <= map_s[7:0];
                key_broken_r <= look_brk_s;
            end
        end
    end

    assign key_data_stb = key_data_stb_r;
    assign key_broken   = key_broken_r;
    assign key_data     = key_data_r;
    assign frame_err    = frame_err_r;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed self-checking bench for ps2_scancode_decoder.
module tb_ps2_scancode_decoder;

    localparam int TMO = 5000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       ps2_clk  = 1'b1;
    logic       ps2_data = 1'b1;
    logic       key_data_stb;
    logic       key_broken;
    logic [7:0] key_data;
    logic       frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_fall = 0;
    int stb_cnt  = 0;
    int err_cnt  = 0;
    int stb_cyc  = 0;
    int err_cyc  = 0;
    logic [7:0] last_data = 8'd0;
    logic       last_brk  = 1'b0;
    logic       prev_stb  = 1'b0;
    logic       consec    = 1'b0;
    int s0, e0;

    ps2_scancode_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ps2_clk      (ps2_clk),
        .ps2_data     (ps2_data),
        .key_data_stb (key_data_stb),
        .key_broken   (key_broken),
        .key_data     (key_data),
        .frame_err    (frame_err)
    );

    always #5 clk = ~clk;

    // Cycle counter used for latency measurement.
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor sampled on the falling clock edge.
    always @(negedge clk) begin
        prev_stb <= key_data_stb;
        if (rst_n) begin
            if (key_data_stb) begin
                stb_cnt   <= stb_cnt + 1;
                stb_cyc   <= cyc;
                last_data <= key_data;
                last_brk  <= key_broken;
                if (prev_stb) consec <= 1'b1;
            end
            if (frame_err) begin
                err_cnt <= err_cnt + 1;
                err_cyc <= cyc;
            end
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive the first nbits bits of a frame: start, 8 data LSB first, parity, stop.
    task automatic send(input logic [7:0] b, input logic par_flip, input logic stop_v,
                        input int nbits, input logic start_v);
        logic [10:0] bits;
        bits = {stop_v, (~^b) ^ par_flip, b, start_v};
        for (int i = 0; i < nbits; i++) begin
            @(posedge clk); #1 ps2_data = bits[i];
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b0;
            last_fall = cyc;
            repeat (10) @(posedge clk);
            #1 ps2_clk = 1'b1;
        end
        repeat (30) @(posedge clk);
        #1 ps2_data = 1'b1;
    endtask

    task automatic good(input logic [7:0] b);
        send(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    initial begin
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_stb", 32'(key_data_stb), 32'd0);
        check_eq("rst_brk", 32'(key_broken), 32'd0);
        check_eq("rst_data", 32'(key_data), 32'd0);
        check_eq("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        // Plain make of A, with exact strobe latency
        s0 = stb_cnt;
        good(8'h1C);
        check_eq("make_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("make_data", 32'(last_data), 32'h01);
        check_eq("make_brk", 32'(last_brk), 32'd0);
        check_eq("make_lat", 32'(stb_cyc - last_fall), 32'd4);

        // Break of A
        s0 = stb_cnt;
        good(8'hF0); good(8'h1C);
        check_eq("brk_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("brk_data", 32'(last_data), 32'h01);
        check_eq("brk_brk", 32'(last_brk), 32'd1);

        // Extended break of right alt
        s0 = stb_cnt;
        good(8'hE0); good(8'hF0); good(8'h11);
        check_eq("ebrk_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("ebrk_data", 32'(last_data), 32'h2F);
        check_eq("ebrk_brk", 32'(last_brk), 32'd1);

        // Extended make of right ctrl
        s0 = stb_cnt;
        good(8'hE0); good(8'h14);
        check_eq("emk_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("emk_data", 32'(last_data), 32'h2E);
        check_eq("emk_brk", 32'(last_brk), 32'd0);

        // Parity error, then recovery
        s0 = stb_cnt; e0 = err_cnt;
        send(8'h1C, 1'b1, 1'b1, 11, 1'b0);
        check_eq("par_err", 32'(err_cnt - e0), 32'd1);
        check_eq("par_stb", 32'(stb_cnt - s0), 32'd0);
        check_eq("par_lat", 32'(err_cyc - last_fall), 32'd3);
        good(8'h16);
        check_eq("par_rec_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("par_rec_data", 32'(last_data), 32'h1C);
        check_eq("par_rec_brk", 32'(last_brk), 32'd0);

        // Break prefix cancelled by a bad stop bit
        s0 = stb_cnt; e0 = err_cnt;
        good(8'hF0);
        send(8'h24, 1'b0, 1'b0, 11, 1'b0);
        good(8'h1C);
        check_eq("stop_err", 32'(err_cnt - e0), 32'd1);
        check_eq("stop_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("stop_data", 32'(last_data), 32'h01);
        check_eq("stop_brk", 32'(last_brk), 32'd0);

        // Timeout after 5 bits
        s0 = stb_cnt; e0 = err_cnt;
        send(8'h45, 1'b0, 1'b1, 5, 1'b0);
        repeat (TMO + 100) @(posedge clk);
        #1;
        check_eq("tmo_err", 32'(err_cnt - e0), 32'd1);
        check_eq("tmo_stb", 32'(stb_cnt - s0), 32'd0);
        good(8'h45);
        check_eq("tmo_rec_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("tmo_rec_data", 32'(last_data), 32'h1B);

        // Pause sequence is swallowed
        s0 = stb_cnt; e0 = err_cnt;
        good(8'hE1); good(8'h14); good(8'h77); good(8'hE1);
        good(8'hF0); good(8'h14); good(8'hF0); good(8'h77);
        check_eq("pause_stb", 32'(stb_cnt - s0), 32'd0);
        check_eq("pause_err", 32'(err_cnt - e0), 32'd0);
        good(8'h33);
        check_eq("pause_rec_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("pause_rec_data", 32'(last_data), 32'h08);

        // Start bit sampled as 1
        s0 = stb_cnt; e0 = err_cnt;
        send(8'h00, 1'b0, 1'b1, 1, 1'b1);
        check_eq("start_err", 32'(err_cnt - e0), 32'd1);
        check_eq("start_lat", 32'(err_cyc - last_fall), 32'd3);
        good(8'h1A);
        check_eq("start_rec_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("start_rec_data", 32'(last_data), 32'h1A);

        // Reset in the middle of a frame
        send(8'h58, 1'b0, 1'b1, 6, 1'b0);
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        check_eq("mrst_data", 32'(key_data), 32'd0);
        check_eq("mrst_stb", 32'(key_data_stb), 32'd0);
        check_eq("mrst_brk", 32'(key_broken), 32'd0);
        check_eq("mrst_err", 32'(frame_err), 32'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        s0 = stb_cnt;
        good(8'h58);
        check_eq("mrst_rec_cnt", 32'(stb_cnt - s0), 32'd1);
        check_eq("mrst_rec_data", 32'(last_data), 32'h2C);
        check_eq("mrst_rec_brk", 32'(last_brk), 32'd0);

        // Unmapped extended code and discarded control byte
        s0 = stb_cnt; e0 = err_cnt;
        good(8'hE0); good(8'h12); good(8'hAA);
        check_eq("unmap_stb", 32'(stb_cnt - s0), 32'd0);
        check_eq("unmap_err", 32'(err_cnt - e0), 32'd0);

        check_eq("no_consec", 32'(consec), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
